// File: rtl/icache_refill_pkg.sv
// icache_refill_pkg: shared constants and the FSM state encoding for the
// instruction-cache refill engine.
//   CACHE_LINE_WIDTH  icache line width in bits
//   REFILL_BUS_WIDTH  memory read-data width in bits
//   REFILL_BEATS      beats per line fill
//   RRESP_OKAY        read response code for a good beat
//   WDATA_EN          active level of the icache write enable
package icache_refill_pkg;

  localparam int CACHE_LINE_WIDTH  = 64;
  localparam int REFILL_BUS_WIDTH  = 32;
  localparam int REFILL_ADDR_WIDTH = 32;
  localparam int REFILL_BEATS      = CACHE_LINE_WIDTH / REFILL_BUS_WIDTH;

  localparam logic [1:0] RRESP_OKAY = 2'b00;
  localparam logic       WDATA_EN   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RECV  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DRAIN = 3'd4
  } refill_state_e;

endpackage

// File: rtl/icache_refill_line_buf.sv
// refill_line_buf: beat counter plus line insert register. Beat k lands in
// line bits [k*BUS_W +: BUS_W] (little-endian beat order). The counter
// saturates at BEATS so any surplus beats from a malformed burst are ignored.
//   clk, rstn    clock, synchronous active-low reset
//   clear        restart a fill: zero the line and the counter
//   beat_valid   a beat is accepted this cycle
//   beat_data    the beat's data
//   line         assembled line
//   count        beats accepted so far (saturating at BEATS)
module refill_line_buf #(
  parameter int LINE_W = 64,
  parameter int BUS_W  = 32,
  parameter int CNT_W  = $clog2(LINE_W / BUS_W + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              beat_valid,
  input  logic [BUS_W-1:0]  beat_data,
  output logic [LINE_W-1:0] line,
  output logic [CNT_W-1:0]  count
);

  localparam int BEATS = LINE_W / BUS_W;

  logic [BEATS-1:0][BUS_W-1:0] line_q;

  assign line = line_q;

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      line_q <= '0;
      count  <= '0;
    end else if (beat_valid && count != CNT_W'(BEATS)) begin
      for (int i = 0; i < BEATS; i++) begin
        if (count == CNT_W'(i)) line_q[i] <= beat_data;
      end
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/icache_refill.sv
// icache_refill: miss-side refill engine for the 4-way icache. Accepts a
// miss, issues one line-aligned burst read, assembles the beats and hands the
// line to the cache write port with a one-cycle strobe. Bus errors and
// malformed bursts abort the fill with a one-cycle refill_err; a fence.i
// during the burst silently discards the line. The burst always runs to
// r_last so the memory side never sees an abandoned transaction.
//   clk, rstn      clock, synchronous active-low reset
//   fencei_flush   drop any pending fill
//   miss_*         fetch refill request (valid/ready, address)
//   ar_*           burst read address channel
//   r_*            burst read data channel
//   refill_wen     one-cycle icache write strobe
//   refill_data    assembled line (held until the next accepted miss)
//   refill_addr    line-aligned fill address
//   refill_err     one-cycle pulse when a fill is aborted on error
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int LINE_W = CACHE_LINE_WIDTH,
  parameter int BUS_W  = REFILL_BUS_WIDTH,
  parameter int ADDR_W = REFILL_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fencei_flush,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ready,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [7:0]        ar_len,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [BUS_W-1:0]  r_data,
  input  logic [1:0]        r_resp,
  input  logic              r_last,
  output logic              refill_wen,
  output logic [LINE_W-1:0] refill_data,
  output logic [ADDR_W-1:0] refill_addr,
  output logic              refill_err
);

  localparam int BEATS = LINE_W / BUS_W;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int OFF_W = $clog2(LINE_W / 8);

  refill_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q, drop_q;
  logic [CNT_W-1:0]  beat_cnt;
  logic              miss_acc, beat_acc, beat_final, beat_err;
  logic              err_now, drop_now, in_burst;
  logic              unused_lo;

  assign miss_acc = (state_q == ST_IDLE) && miss_valid;
  assign beat_acc = (state_q == ST_RECV) && r_valid;
  assign in_burst = (state_q == ST_REQ) || (state_q == ST_RECV);

  // The beat in slot BEATS-1 (or any surplus beat) must carry r_last and no
  // earlier beat may, so a mismatch either way is a protocol error.
  assign beat_final = beat_cnt >= CNT_W'(BEATS - 1);
  assign beat_err   = beat_acc && ((r_resp != RRESP_OKAY) || (r_last != beat_final));

  // Include this cycle's beat error / flush so the final beat decides
  // WRITE vs DRAIN without waiting for the flags to register.
  assign err_now  = err_q || beat_err;
  assign drop_now = drop_q || fencei_flush;

  // Offset bits inside the line are intentionally discarded.
  assign unused_lo = ^miss_addr[OFF_W-1:0];

  refill_line_buf #(
    .LINE_W (LINE_W),
    .BUS_W  (BUS_W),
    .CNT_W  (CNT_W)
  ) u_line_buf (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (miss_acc),
    .beat_valid (beat_acc),
    .beat_data  (r_data),
    .line       (refill_data),
    .count      (beat_cnt)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (miss_valid) state_d = ST_REQ;
      ST_REQ:   if (ar_ready)   state_d = ST_RECV;
      ST_RECV:  if (beat_acc && r_last)
                  state_d = (err_now || drop_now) ? ST_DRAIN : ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // outputs, decoded from state (fence.i can still veto the write strobe)
  always_comb begin
    miss_ready = 1'b0;
    ar_valid   = 1'b0;
    r_ready    = 1'b0;
    refill_wen = 1'b0;
    refill_err = 1'b0;
    unique case (state_q)
      ST_IDLE:  miss_ready = 1'b1;
      ST_REQ:   ar_valid   = 1'b1;
      ST_RECV:  r_ready    = 1'b1;
      ST_WRITE: refill_wen = WDATA_EN & ~fencei_flush;
      ST_DRAIN: refill_err = err_q;
      default:  ;
    endcase
  end

  // fill context: aligned address plus sticky error / drop flags
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q <= '0;
      err_q  <= 1'b0;
      drop_q <= 1'b0;
    end else if (miss_acc) begin
      addr_q <= {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      err_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      if (beat_err)                 err_q  <= 1'b1;
      if (fencei_flush && in_burst) drop_q <= 1'b1;
    end
  end

  assign ar_addr     = addr_q;
  assign refill_addr = addr_q;
  assign ar_len      = 8'(BEATS - 1);

endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: scenario tasks drive the miss and memory sides with
// fixed cycle timing; expected write/error events are queued when the final
// beat is driven and a negedge monitor pops and compares them.
module tb_icache_refill;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fencei_flush = 1'b0;
  logic        miss_valid = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        miss_ready;
  logic        ar_valid;
  logic        ar_ready = 1'b0;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic        r_valid = 1'b0;
  logic        r_ready;
  logic [31:0] r_data = '0;
  logic [1:0]  r_resp = '0;
  logic        r_last = 1'b0;
  logic        refill_wen;
  logic [63:0] refill_data;
  logic [31:0] refill_addr;
  logic        refill_err;

  icache_refill dut (
    .clk          (clk),
    .rstn         (rstn),
    .fencei_flush (fencei_flush),
    .miss_valid   (miss_valid),
    .miss_addr    (miss_addr),
    .miss_ready   (miss_ready),
    .ar_valid     (ar_valid),
    .ar_ready     (ar_ready),
    .ar_addr      (ar_addr),
    .ar_len       (ar_len),
    .r_valid      (r_valid),
    .r_ready      (r_ready),
    .r_data       (r_data),
    .r_resp       (r_resp),
    .r_last       (r_last),
    .refill_wen   (refill_wen),
    .refill_data  (refill_data),
    .refill_addr  (refill_addr),
    .refill_err   (refill_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic        wen;
    logic        err;
    logic [63:0] data;
    logic [31:0] addr;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;

  // scoreboard consumer: every write strobe or error pulse must match the
  // next queued expectation, including the cycle it occurs in
  always @(negedge clk) begin
    if (refill_wen === 1'b1 || refill_err === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: wen=%b err=%b at cyc %0d, want no event",
                 refill_wen, refill_err, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (refill_wen !== mon_e.wen || refill_err !== mon_e.err || cyc !== mon_e.cyc ||
            (mon_e.wen && (refill_data !== mon_e.data || refill_addr !== mon_e.addr))) begin
          n_fail++;
          $display("FAIL event: wen=%b err=%b cyc=%0d data=%h addr=%h, want wen=%b err=%b cyc=%0d data=%h addr=%h",
                   refill_wen, refill_err, cyc, refill_data, refill_addr,
                   mon_e.wen, mon_e.err, mon_e.cyc, mon_e.data, mon_e.addr);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // One complete miss. nb = beats sent (r_last on the final one), resp1 is
  // the response on beat index 1, flush_* place fence.i in the accept cycle,
  // the gap before beat 1, or the WRITE cycle.
  task automatic do_miss(input string nm, input logic [31:0] addr, input int ar_wait,
                         input int gap, input int nb, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [1:0] resp1, input bit flush_acc,
                         input bit flush_gap, input bit flush_wr);
    logic [31:0] al;
    logic [63:0] line;
    logic [31:0] d[3];
    bit          exp_err, exp_wen;
    exp_t        e;
    d[0] = d0; d[1] = d1; d[2] = d2;
    al      = addr & 32'hFFFF_FFF8;
    line    = {d1, d0};
    exp_err = (nb != 2) || (resp1 != 2'b00);
    exp_wen = !exp_err && !flush_gap && !flush_wr;

    nxt();
    miss_valid = 1'b1; miss_addr = addr; fencei_flush = flush_acc;
    @(negedge clk);
    n_cmp++;
    if (miss_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s.accept: miss_ready=%b want 1", nm, miss_ready);
    end
    nxt();
    miss_valid = 1'b0; fencei_flush = 1'b0; miss_addr = $urandom;
    for (int i = 0; i <= ar_wait; i++) begin
      ar_ready = (i == ar_wait);
      @(negedge clk);
      n_cmp++;
      if (ar_valid !== 1'b1 || ar_addr !== al || ar_len !== 8'd1) begin
        n_fail++;
        $display("FAIL %s.ar[%0d]: ar_valid=%b ar_addr=%h ar_len=%0d want 1 %h 1",
                 nm, i, ar_valid, ar_addr, ar_len, al);
      end
      nxt();
    end
    ar_ready = 1'b0;
    for (int b = 0; b < nb; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          r_valid = 1'b0; fencei_flush = flush_gap;
          @(negedge clk);
          n_cmp++;
          if (r_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s.gap[%0d]: r_ready=%b want 1", nm, g, r_ready);
          end
          nxt();
        end
      end
      fencei_flush = 1'b0;
      r_valid = 1'b1; r_data = d[b];
      r_resp  = (b == 1) ? resp1 : 2'b00;
      r_last  = (b == nb - 1);
      if (b == nb - 1 && (exp_err || exp_wen)) begin
        e.wen = exp_wen; e.err = exp_err; e.data = line; e.addr = al; e.cyc = cyc + 1;
        sb.push_back(e);
      end
      @(negedge clk);
      n_cmp++;
      if (r_ready !== 1'b1) begin
        n_fail++; $display("FAIL %s.beat[%0d]: r_ready=%b want 1", nm, b, r_ready);
      end
      nxt();
    end
    r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00; fencei_flush = flush_wr;
    @(negedge clk);
    nxt();
    fencei_flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (miss_ready !== 1'b1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s.done: miss_ready=%b pending=%0d want 1 0", nm, miss_ready, sb.size());
      sb.delete();
    end
    if (exp_wen) begin
      n_cmp++;
      if (refill_data !== line || refill_addr !== al) begin
        n_fail++;
        $display("FAIL %s.hold: data=%h addr=%h want %h %h", nm, refill_data, refill_addr, line, al);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) nxt();
    @(negedge clk);
    n_cmp++;
    if (miss_ready !== 1'b1 || ar_valid !== 1'b0 || r_ready !== 1'b0 || refill_wen !== 1'b0 ||
        refill_err !== 1'b0 || refill_data !== 64'h0 || refill_addr !== 32'h0 || ar_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b arv=%b rr=%b wen=%b err=%b data=%h addr=%h araddr=%h want 1 0 0 0 0 0 0 0",
               miss_ready, ar_valid, r_ready, refill_wen, refill_err, refill_data, refill_addr, ar_addr);
    end
    nxt();
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    do_miss("basic", 32'h8000_0014, 0, 0, 2, 32'h1111_2222, 32'h3333_4444, 32'h0,
            2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_miss("backpressure", 32'h8000_0014, 3, 1, 2, 32'h1111_2222, 32'h3333_4444, 32'h0,
            2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_bus_error();
    do_miss("bus_error", 32'h0000_1238, 0, 0, 2, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0,
            2'b10, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_flush_mid();
    do_miss("flush_mid", 32'h4000_0100, 0, 1, 2, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0,
            2'b00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_flush_write();
    do_miss("flush_write", 32'h4000_0208, 1, 0, 2, 32'h0123_4567, 32'h89AB_CDEF, 32'h0,
            2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_flush_idle();
    do_miss("flush_idle", 32'h0000_0FFF, 0, 0, 2, 32'h5555_6666, 32'h7777_8888, 32'h0,
            2'b00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_early_last();
    do_miss("early_last", 32'h2000_0040, 0, 0, 1, 32'h1234_5678, 32'h0, 32'h0,
            2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_missing_last();
    do_miss("missing_last", 32'h2000_0048, 0, 0, 3, 32'h0000_0001, 32'h0000_0002,
            32'h0000_0003, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    nxt();
    miss_valid = 1'b1; miss_addr = 32'h9000_0010;
    nxt();
    miss_valid = 1'b0; ar_ready = 1'b1;
    nxt();
    ar_ready = 1'b0; r_valid = 1'b1; r_data = 32'hFEED_FACE; r_last = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (r_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid.recv: r_ready=%b want 1", r_ready);
    end
    nxt();
    r_valid = 1'b0; rstn = 1'b0;
    nxt();
    @(negedge clk);
    n_cmp++;
    if (miss_ready !== 1'b1 || ar_valid !== 1'b0 || r_ready !== 1'b0 || refill_wen !== 1'b0 ||
        refill_err !== 1'b0 || refill_data !== 64'h0 || refill_addr !== 32'h0 || ar_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: rdy=%b arv=%b rr=%b wen=%b err=%b data=%h addr=%h araddr=%h want 1 0 0 0 0 0 0 0",
               miss_ready, ar_valid, r_ready, refill_wen, refill_err, refill_data, refill_addr, ar_addr);
    end
    rstn = 1'b1;
    nxt();
  endtask

  task automatic test_back_to_back();
    do_miss("b2b0", 32'h1000_0004, 0, 0, 2, 32'hA5A5_0000, 32'h5A5A_1111, 32'h0,
            2'b00, 1'b0, 1'b0, 1'b0);
    do_miss("b2b1", 32'h1000_0008, 0, 0, 2, 32'h0F0F_2222, 32'hF0F0_3333, 32'h0,
            2'b00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      do_miss("rand", $urandom, int'($urandom_range(2)), int'($urandom_range(2)), 2,
              $urandom, $urandom, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bus_error();
    test_flush_mid();
    test_flush_write();
    test_flush_idle();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    test_back_to_back();
    repeat (3) nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
# icache_refill

Miss-side refill engine for the 4-way instruction cache. When fetch reports a miss, it issues one line-aligned burst read to memory, assembles the returned beats into a full cache line, and presents that line to the cache's write port with a single-cycle write enable. The cache selects the victim way (PLRU). It sits between the fetch/icache control path and the memory read bus.

## Interface
- LINE_W, 64: cache line width in bits; equals `CACHE_LINE_WIDTH.
- BUS_W, 32: memory read-data width; LINE_W must be a multiple of BUS_W.
- ADDR_W, 32: physical address width.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- fencei_flush  in  1  fence.i flush; suppresses any pending fill.
- miss_valid  in  1  fetch requests a refill.
- miss_addr  in  ADDR_W  miss address; any byte within the line.
- miss_ready  out  1  engine idle; request accepted when valid && ready.
- ar_valid  out  1  read-address request valid.
- ar_ready  in  1  memory accepts address.
- ar_addr  out  ADDR_W  line-aligned address; low log2(LINE_W/8) bits are 0.
- ar_len  out  8  beats minus 1, i.e. LINE_W/BUS_W-1.
- r_valid  in  1  read beat valid.
- r_ready  out  1  engine accepts beat.
- r_data  in  BUS_W  beat data.
- r_resp  in  2  0 = OK; any other value = error.
- r_last  in  1  final beat of burst.
- refill_wen  out  1  one-cycle write strobe to the icache wen.
- refill_data  out  LINE_W  assembled line to the icache wcache_data.
- refill_addr  out  ADDR_W  line-aligned address of the fill, used for tag/index.
- refill_err  out  1  one-cycle pulse; the fill was aborted due to a bus error.

## Operation
- FSM states: IDLE, REQ, RECV, WRITE, DRAIN.
- IDLE: miss_ready=1. On miss_valid, latch the aligned address, clear the beat counter and the error and drop flags, and go to REQ.
- REQ: ar_valid=1, with ar_addr and ar_len held stable. On ar_ready, go to RECV.
- RECV: r_ready=1. Each accepted beat k writes line bits [k*BUS_W +: BUS_W], little-endian beat order, and the counter increments.
  - r_resp≠0 on any beat sets the error flag.
  - r_last on beat BEATS-1: go to WRITE if no error and no drop; otherwise go to DRAIN.
  - r_last before beat BEATS-1, or no r_last on beat BEATS-1, counts as an error. In the second case, stay in RECV with r_ready=1 until r_last arrives.
- WRITE: refill_wen=1 unless fencei_flush is high this cycle. refill_data and refill_addr are valid. Go to IDLE next.
- DRAIN: refill_err=1 if the error flag is set; refill_wen=0. Go to IDLE next.
- fencei_flush in REQ or RECV sets the drop flag. The bus transaction always runs to r_last and is never abandoned. The line is then discarded via DRAIN with no error pulse unless a bus error also occurred.
- fencei_flush in IDLE has no effect. A miss_valid in the same cycle is still accepted.

## Timing
- Reset values: state IDLE, miss_ready=1, ar_valid=0, r_ready=0, refill_wen=0, refill_err=0, refill_data=0, refill_addr=0, ar_addr=0.
- Reset asserted mid-operation returns the FSM to IDLE in the next cycle. The memory side must be reset in the same cycle; no drain is performed.
- Minimum latency with BEATS=2, accept at cycle T:
  - T+1: ar_valid with ar_ready.
  - T+2 and T+3: beats.
  - T+4: refill_wen.
  - T+5: miss_ready=1.
- Each wait-state on ar_ready or r_valid adds exactly one cycle.
- refill_data and refill_addr hold their values from WRITE until the next accepted miss.
- Outputs are registered or decoded from state only; none depend combinationally on r_valid or r_data.

## Structure
- params.v gains `REFILL_BUS_WIDTH, `REFILL_BEATS, `RRESP_OKAY, and the five state encodings.
- `CACHE_LINE_WIDTH and `WDATA_EN are reused from params.v.
- One natural sub-module, refill_line_buf: beat counter plus line shift/insert register. It has clear, beat-valid, and data inputs, and full-line and count outputs.

## Test plan
- Basic fill: miss_addr=0x8000_0014, ar_ready immediate, beats 0x1111_2222 then 0x3333_4444 with r_last on beat 2. Expect ar_addr=0x8000_0010 and ar_len=1. Expect refill_data=0x3333_4444_1111_2222 with refill_wen high exactly one cycle at T+4.
- Backpressure: ar_ready delayed 3 cycles, one idle cycle between beats. Expect ar_addr stable throughout, wen at T+8, same data.
- Bus error: second beat with r_resp=2. Expect refill_err pulse for one cycle, no refill_wen, miss_ready back the next cycle.
- Flush mid-burst: fencei_flush after beat 1. Expect the burst to complete with r_ready held, no refill_wen, no refill_err.
- Flush in WRITE cycle: expect refill_wen=0 that cycle.
- Early r_last on beat 1: expect refill_err and no refill_wen. Separately, rstn low during RECV: expect all outputs at their reset values the next cycle.
